// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain load/unload sequencer.
// Holds the FSM state encoding, the counter-width helper and the default fill value.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Scan cells set to 1, so refilling with 1 leaves the chain in its reset-like state.
    localparam logic FILL_BIT_DEF = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, right-shifting register with a serial input at the MSB.
// Bit 0 is the serial output side; the shift-in value enters at the top.
module scan_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // A parallel load takes priority over a shift in the same cycle.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = {sin, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/scan_shift_ctrl.sv
// Serial load/unload sequencer for one scan chain: shifts a pattern in LSB first,
// optionally pulses one capture cycle, then shifts the chain out into a response word.
module scan_shift_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int   CHAIN_LEN = 16,
    parameter logic FILL_BIT  = FILL_BIT_DEF
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [CHAIN_LEN-1:0] req_pat,
    input  logic                 req_cap,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 busy
);

    localparam int              CNT_W    = clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cap_q, cap_d;
    logic                 pat_load;
    logic                 pat_shift;
    logic                 rsp_shift;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] rsp_q;
    logic                 unused_pat_hi;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        pat_load  = 1'b0;
        pat_shift = 1'b0;
        rsp_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    pat_load = 1'b1;
                    cap_d    = req_cap;
                    cnt_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                pat_shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = cap_q ? CAPTURE : UNLOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURE: begin
                state_d = UNLOAD;
            end
            UNLOAD: begin
                rsp_shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan pins decode only registered state so nothing on req_* reaches the chain combinationally.
    always_comb begin
        req_rdy = 1'b0;
        rsp_vld = 1'b0;
        scan_se = 1'b0;
        scan_si = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
            end
            LOAD: begin
                scan_se = 1'b1;
                scan_si = pat_q[0];
            end
            UNLOAD: begin
                scan_se = 1'b1;
                scan_si = FILL_BIT;
            end
            RESP: begin
                rsp_vld = 1'b1;
            end
            default: begin
                req_rdy = 1'b0;
            end
        endcase
    end

    scan_shift_reg #(
        .WIDTH (CHAIN_LEN)
    ) u_pat_reg (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .load     (pat_load),
        .load_val (req_pat),
        .shift    (pat_shift),
        .sin      (1'b0),
        .q        (pat_q)
    );

    // The first SO sample ends up in bit 0 after CHAIN_LEN shifts.
    scan_shift_reg #(
        .WIDTH (CHAIN_LEN)
    ) u_rsp_reg (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .load     (1'b0),
        .load_val ('0),
        .shift    (rsp_shift),
        .sin      (scan_so),
        .q        (rsp_q)
    );

    assign rsp_data      = rsp_q;
    assign unused_pat_hi = ^pat_q[CHAIN_LEN-1:1];

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Bench for scan_shift_ctrl: a 16-flop set-to-1 scan chain model around the DUT and a
// transaction-level reference that predicts every output from the accept cycle offset.
module tb_scan_shift_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [N-1:0] req_pat = '0;
    logic         req_cap = 1'b0;
    logic         rsp_vld;
    logic         rsp_rdy = 1'b0;
    logic [N-1:0] rsp_data;
    logic         scan_se;
    logic         scan_si;
    logic         scan_so;
    logic         busy;

    always #5 clk = ~clk;

    scan_shift_ctrl #(
        .CHAIN_LEN (N),
        .FILL_BIT  (1'b1)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_pat        (req_pat),
        .req_cap        (req_cap),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_data       (rsp_data),
        .scan_se        (scan_se),
        .scan_si        (scan_si),
        .scan_so        (scan_so),
        .busy           (busy)
    );

    // Chain model: ch[N-1] drives SO. Bit k of d_word feeds the flop k places from SO,
    // so a capture followed by unload returns d_word. With d_tie_en low the functional
    // logic holds each flop's value.
    logic [N-1:0] ch = '1;
    logic         d_tie_en = 1'b0;
    logic [N-1:0] d_word = '0;

    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (scan_se === 1'b1) ch <= {ch[N-2:0], scan_si};
        else if (scan_se === 1'b0 && d_tie_en) ch <= rev(d_word);
    end
    assign scan_so = ch[N-1];

    // Reference: a transaction is a pattern accepted at cycle m_acc_t; every output follows
    // from the offset into it (N load cycles, optional capture, N unload cycles, response).
    int           cyc = 0;
    bit           m_txn = 1'b0;
    int           m_acc_t = 0;
    logic [N-1:0] m_pat = '0;
    logic [N-1:0] m_exp = '0;
    bit           m_cap = 1'b0;
    int           n_acc = 0;
    int           n_rsp = 0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        int o;
        o = cyc - m_acc_t;
        if (rst) begin
            m_txn  = 1'b0;
            chk_en = 1'b1;
        end else if (!m_txn) begin
            if (req_vld) begin
                m_txn   = 1'b1;
                m_acc_t = cyc;
                m_pat   = req_pat;
                m_cap   = req_cap;
                m_exp   = (req_cap && d_tie_en) ? d_word : req_pat;
                n_acc++;
            end
        end else if (o >= 2*N + 1 + int'(m_cap) && rsp_rdy) begin
            m_txn = 1'b0;
            n_rsp++;
        end
        cyc++;
    end

    int           nvec = 0;
    int           nerr = 0;
    int           last_lat = -1;
    int           vld_seen = 0;
    bit           prev_vld = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int o;
        int u0;
        bit e_vld, e_se, e_si;
        if (chk_en) begin
            o = cyc - m_acc_t;
            u0 = N + 1 + int'(m_cap);
            e_vld = 1'b0;
            e_se = 1'b0;
            e_si = 1'b0;
            if (m_txn) begin
                if (o >= 1 && o <= N) begin
                    e_se = 1'b1;
                    e_si = m_pat[o-1];
                end else if (o >= u0 && o < u0 + N) begin
                    e_se = 1'b1;
                    e_si = 1'b1;
                end else if (o >= u0 + N) begin
                    e_vld = 1'b1;
                end
            end
            chk1("req_rdy", req_rdy, !m_txn);
            chk1("busy", busy, m_txn);
            chk1("rsp_vld", rsp_vld, e_vld);
            chk1("scan_se", scan_se, e_se);
            chk1("scan_si", scan_si, e_si);
            if (e_vld) chkw("rsp_data", rsp_data, m_exp);
            if (rsp_vld === 1'b1 && !prev_vld) last_lat = o;
            if (rsp_vld === 1'b1) vld_seen++;
            prev_vld = (rsp_vld === 1'b1);
        end
    end

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] p, input bit c, input bit keep);
        int n0;
        int k;
        n0 = n_acc;
        k = 0;
        req_pat = p;
        req_cap = c;
        req_vld = 1'b1;
        while (n_acc == n0 && k < 200) begin
            nedge();
            k++;
        end
        if (n_acc == n0) chki("accept_timeout", n_acc, n0 + 1);
        if (!keep) req_vld = 1'b0;
    endtask

    task automatic wait_resp();
        int k;
        k = 0;
        while (!(m_txn && (cyc - m_acc_t) >= 2*N + 1 + int'(m_cap)) && k < 200) begin
            nedge();
            k++;
        end
        if (k >= 200) chki("resp_timeout", k, 0);
    endtask

    task automatic release_rsp();
        int n0;
        int k;
        n0 = n_rsp;
        k = 0;
        rsp_rdy = 1'b1;
        while (n_rsp == n0 && k < 200) begin
            nedge();
            k++;
        end
        rsp_rdy = 1'b0;
        if (n_rsp == n0) chki("handshake_timeout", n_rsp, n0 + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int se0;
        int k;
        int vs;
        logic [N-1:0] held;

        repeat (3) nedge();
        chk1("reset_req_rdy", req_rdy, 1'b1);
        chk1("reset_rsp_vld", rsp_vld, 1'b0);
        chk1("reset_scan_se", scan_se, 1'b0);
        chk1("reset_scan_si", scan_si, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        rst = 1'b0;
        nedge();

        // Loopback, no capture
        d_tie_en = 1'b0;
        send(16'hA5C3, 1'b0, 1'b0);
        wait_resp();
        chki("loop_latency", last_lat, 33);
        chkw("loop_data", rsp_data, 16'hA5C3);
        release_rsp();
        chkw("fill_chain_after_unload", ch, 16'hFFFF);

        // Second readback of an all-zero load
        send(16'h0000, 1'b0, 1'b0);
        wait_resp();
        chkw("zero_data", rsp_data, 16'h0000);
        release_rsp();
        chkw("fill_chain_again", ch, 16'hFFFF);

        // Capture path
        d_tie_en = 1'b1;
        d_word = 16'h1234;
        send(16'hFFFF, 1'b1, 1'b0);
        se0 = 0;
        k = 0;
        while (!(rsp_vld === 1'b1) && k < 100) begin
            if (scan_se === 1'b0) se0++;
            nedge();
            k++;
        end
        chki("cap_se_low_cycles", se0, 1);
        chki("cap_latency", last_lat, 34);
        chkw("cap_data", rsp_data, 16'h1234);
        release_rsp();
        d_tie_en = 1'b0;

        // Response backpressure
        send(16'h5A3C, 1'b0, 1'b0);
        wait_resp();
        held = rsp_data;
        repeat (10) begin
            chk1("bp_rsp_vld", rsp_vld, 1'b1);
            chkw("bp_rsp_data", rsp_data, 16'h5A3C);
            chkw("bp_rsp_stable", rsp_data, held);
            chk1("bp_req_rdy", req_rdy, 1'b0);
            nedge();
        end
        rsp_rdy = 1'b1;
        nedge();
        rsp_rdy = 1'b0;
        chk1("bp_release_req_rdy", req_rdy, 1'b1);
        chk1("bp_release_busy", busy, 1'b0);
        chk1("bp_release_rsp_vld", rsp_vld, 1'b0);

        // Request held while busy
        send(16'h3C96, 1'b0, 1'b1);
        req_pat = 16'h0F0F;
        wait_resp();
        chkw("busy_first_data", rsp_data, 16'h3C96);
        rsp_rdy = 1'b1;
        nedge();
        rsp_rdy = 1'b0;
        chk1("busy_idle_req_rdy", req_rdy, 1'b1);
        nedge();
        req_vld = 1'b0;
        chk1("busy_second_accepted", busy, 1'b1);
        chk1("busy_second_se", scan_se, 1'b1);
        chk1("busy_second_si", scan_si, 1'b1);
        wait_resp();
        chkw("busy_second_data", rsp_data, 16'h0F0F);
        release_rsp();

        // Reset while cnt = 7 in LOAD
        send(16'hC0DE, 1'b0, 1'b0);
        repeat (7) nedge();
        rst = 1'b1;
        nedge();
        chk1("rst_mid_req_rdy", req_rdy, 1'b1);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_scan_se", scan_se, 1'b0);
        chk1("rst_mid_rsp_vld", rsp_vld, 1'b0);
        rst = 1'b0;
        vs = vld_seen;
        repeat (50) nedge();
        chki("rst_mid_no_response", vld_seen - vs, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            d_tie_en = 1'($urandom_range(0, 1));
            d_word = N'($urandom);
            send(N'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            wait_resp();
            repeat ($urandom_range(0, 4)) nedge();
            release_rsp();
            repeat ($urandom_range(0, 2)) nedge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
